// File: rtl/redun_sq_sched_pkg.sv
// Shared types for the VDF squaring scheduler: redundant-form operand,
// scheduler state encoding and sticky error bit positions.
package redun_sq_sched_pkg;

    localparam int NUM_WRDS = 4;
    localparam int WRD_BITS = 16;

    // Redundant-form operand as carried between the scheduler and redun_mont.
    typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] redun0_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int SCHED_ERR_TMO  = 0;
    localparam int SCHED_ERR_SPUR = 1;

endpackage

// File: rtl/redun_sq_sched_if.sv
// Handshake between the squaring scheduler (master) and the redun_mont
// datapath (slave): one operand out per issue strobe, one result back.
interface redun_sq_sched_if;
    import redun_sq_sched_pkg::*;

    logic    o_mont_rst;
    redun0_t o_mont_sq;
    logic    o_mont_val;
    redun0_t i_mont_mul;
    logic    i_mont_val;

    modport master (
        output o_mont_rst, o_mont_sq, o_mont_val,
        input  i_mont_mul, i_mont_val
    );

    modport slave (
        input  o_mont_rst, o_mont_sq, o_mont_val,
        output i_mont_mul, i_mont_val
    );

endinterface

// File: rtl/redun_sq_sched.sv
// VDF squaring scheduler: loads a start value, issues one squaring at a time
// to redun_mont, feeds each result back and returns the value after i_iters
// squarings. A per-iteration watchdog and abort both reset the datapath.
module redun_sq_sched
    import redun_sq_sched_pkg::*;
#(
    parameter int ITER_W  = 64,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ITER_W-1:0]     i_iters,
    input  redun0_t               i_sq,
    input  logic                  i_abort,
    redun_sq_sched_if.master      mont,
    output logic                  o_busy,
    output logic                  o_done,
    output redun0_t               o_result,
    output logic [ITER_W-1:0]     o_iter_cnt,
    output logic [1:0]            o_err
);

    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]  WD_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

    sched_state_t      state_r, state_s;
    redun0_t           operand_r, operand_s;
    redun0_t           result_r, result_s;
    redun0_t           mont_sq_r;
    logic [ITER_W-1:0] iters_r, cnt_r, cnt_inc_s;
    logic [TMO_W-1:0]  wd_r;
    logic [1:0]        err_r, err_s;
    logic              accept_s, capture_s, tmo_s, spur_s, fin_s;
    logic              busy_r, done_r, mont_val_r, mont_rst_r, mont_rst_hold_r;

    assign cnt_inc_s = cnt_r + ITER_ONE;
    assign fin_s     = capture_s && (cnt_inc_s == iters_r);
    // A result strobe is only legal while waiting; abort masks everything.
    assign spur_s    = mont.i_mont_val && (state_r != WAIT) && !i_abort;

    // Next-state decode; abort outranks every other event in the cycle.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        capture_s = 1'b0;
        tmo_s     = 1'b0;
        if (i_abort) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_start && !mont_rst_r) begin
                        accept_s = 1'b1;
                        state_s  = (i_iters == {ITER_W{1'b0}}) ? DONE : ISSUE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ISSUE: state_s = WAIT;
                WAIT: begin
                    if (mont.i_mont_val) begin
                        capture_s = 1'b1;
                        state_s   = (cnt_inc_s == iters_r) ? DONE : ISSUE;
                    end else if (wd_r == TMO_LAST) begin
                        tmo_s   = 1'b1;
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT;
                    end
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // Next values of operand, result and sticky errors.
    always_comb begin
        operand_s = operand_r;
        result_s  = result_r;
        err_s     = accept_s ? 2'b00 : err_r;
        if (accept_s) begin
            operand_s = i_sq;
            result_s  = (i_iters == {ITER_W{1'b0}}) ? i_sq : result_r;
        end else if (capture_s) begin
            operand_s = mont.i_mont_mul;
            result_s  = fin_s ? mont.i_mont_mul : result_r;
        end else begin
            operand_s = operand_r;
        end
        err_s[SCHED_ERR_TMO]  = err_s[SCHED_ERR_TMO] | tmo_s;
        err_s[SCHED_ERR_SPUR] = err_s[SCHED_ERR_SPUR] | spur_s;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Run registers, watchdog and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            operand_r       <= '0;
            result_r        <= '0;
            mont_sq_r       <= '0;
            iters_r         <= {ITER_W{1'b0}};
            cnt_r           <= {ITER_W{1'b0}};
            wd_r            <= {TMO_W{1'b0}};
            err_r           <= 2'b00;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            mont_val_r      <= 1'b0;
            mont_rst_r      <= 1'b1;
            mont_rst_hold_r <= 1'b1;
        end else begin
            operand_r  <= operand_s;
            result_r   <= result_s;
            err_r      <= err_s;
            busy_r     <= (state_s == ISSUE) || (state_s == WAIT);
            done_r     <= (state_s == DONE);
            mont_val_r <= (state_s == ISSUE);
            mont_sq_r  <= (state_s == ISSUE) ? operand_s : '0;
            if (accept_s) begin
                iters_r <= i_iters;
                cnt_r   <= {ITER_W{1'b0}};
            end else if (capture_s) begin
                cnt_r <= cnt_inc_s;
            end else begin
                cnt_r <= cnt_r;
            end
            if (state_r == ISSUE) begin
                wd_r <= {TMO_W{1'b0}};
            end else if (state_r == WAIT) begin
                wd_r <= wd_r + WD_ONE;
            end else begin
                wd_r <= wd_r;
            end
            // Two-cycle datapath reset so an in-flight result is dropped.
            if (i_abort || tmo_s) begin
                mont_rst_r      <= 1'b1;
                mont_rst_hold_r <= 1'b1;
            end else if (mont_rst_hold_r) begin
                mont_rst_r      <= 1'b1;
                mont_rst_hold_r <= 1'b0;
            end else begin
                mont_rst_r <= 1'b0;
            end
        end
    end

    assign mont.o_mont_rst = mont_rst_r;
    assign mont.o_mont_sq  = mont_sq_r;
    assign mont.o_mont_val = mont_val_r;
    assign o_busy          = busy_r;
    assign o_done          = done_r;
    assign o_result        = result_r;
    assign o_iter_cnt      = cnt_r;
    assign o_err           = err_r;

endmodule

// File: tb/tb_redun_sq_sched.sv
// Directed bench for redun_sq_sched with a fixed-latency squaring model
// (mod a small prime) and a timestamp-based reference model checked every cycle.
module tb_redun_sq_sched;
    import redun_sq_sched_pkg::*;

    localparam int              L    = 8;
    localparam int              TMO  = 4096;
    localparam longint unsigned NMOD = 64'd1000003;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [63:0] iters = 64'd0;
    redun0_t     sq = '0;
    logic        busy, done;
    redun0_t     result;
    logic [63:0] iter_cnt;
    logic [1:0]  err;

    always #5 clk = ~clk;

    redun_sq_sched_if mif();

    redun_sq_sched dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_iters    (iters),
        .i_sq       (sq),
        .i_abort    (abort),
        .mont       (mif),
        .o_busy     (busy),
        .o_done     (done),
        .o_result   (result),
        .o_iter_cnt (iter_cnt),
        .o_err      (err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    // stimulus controls
    bit drv_rst = 1'b1, drv_start = 1'b0, drv_abort = 1'b0, drv_spur = 1'b0;
    longint unsigned drv_iters = 0, drv_sq = 0;
    bit mont_on = 1'b1;
    int abort_at_resp = 0, resp_no = 0;

    // squaring-datapath model state
    int due = -1;
    longint unsigned due_val = 0;

    // reference model state (timestamps in cycle numbers)
    bit m_valid = 1'b0, m_active = 1'b0;
    int m_issue_at = -1, m_done_at = -1, m_wait_start = 0, m_rst_left = 0;
    longint unsigned m_iters = 0, m_cnt = 0, m_operand = 0, m_result = 0;
    logic [1:0] m_err = 2'b00;

    // observation tallies
    int n_issue = 0, n_done = 0, done_cyc = 0, last_n = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s @cycle %0d: bound expired", name, cyc);
    endtask

    // One clock cycle: compare, run the datapath model, drive inputs, advance the model.
    task automatic step();
        int n;
        bit real_r, mv, rst_now, waiting, issuing, idle_n;
        longint unsigned mul, sqv;
        @(negedge clk);
        n = cyc;
        last_n = n;
        if (m_valid) begin
            chk("mont_rst", 64'(mif.o_mont_rst), 64'(m_rst_left > 0));
            chk("mont_val", 64'(mif.o_mont_val), 64'(n == m_issue_at));
            if (n == m_issue_at) chk("mont_sq", 64'(mif.o_mont_sq), m_operand);
            chk("busy", 64'(busy), 64'(m_active));
            chk("done", 64'(done), 64'(n == m_done_at));
            chk("result", 64'(result), m_result);
            chk("iter_cnt", iter_cnt, m_cnt);
            chk("err", 64'(err), 64'(m_err));
        end
        if (mif.o_mont_val) n_issue++;
        if (done) begin
            n_done++;
            done_cyc = n;
        end
        if (mif.o_mont_rst) due = -1;
        if (mif.o_mont_val && mont_on) begin
            sqv     = 64'(mif.o_mont_sq);
            due     = n + L + 1;
            due_val = (sqv * sqv) % NMOD;
        end
        real_r = (due == n);
        mv     = real_r || drv_spur;
        mul    = real_r ? due_val : 64'd0;
        if (real_r) begin
            due = -1;
            resp_no++;
        end
        mif.i_mont_val = mv;
        mif.i_mont_mul = mul;
        rst   = drv_rst;
        start = drv_start;
        iters = drv_iters;
        sq    = drv_sq;
        abort = drv_abort || (real_r && abort_at_resp != 0 && resp_no == abort_at_resp);

        if (rst) begin
            m_valid = 1'b1; m_active = 1'b0; m_issue_at = -1; m_done_at = -1;
            m_rst_left = 2; m_iters = 0; m_cnt = 0; m_operand = 0; m_result = 0;
            m_err = 2'b00; due = -1;
        end else begin
            rst_now = (m_rst_left > 0);
            if (m_rst_left > 0) m_rst_left--;
            issuing = m_active && (m_issue_at == n);
            waiting = m_active && (m_issue_at != n);
            idle_n  = !m_active && (m_done_at != n);
            if (abort) begin
                m_active = 1'b0; m_issue_at = -1; m_done_at = -1; m_rst_left = 2;
            end else begin
                if (idle_n && start && !rst_now) begin
                    m_err = 2'b00; m_cnt = 0; m_iters = iters; m_operand = sq;
                    if (iters == 64'd0) begin
                        m_result  = sq;
                        m_done_at = n + 1;
                    end else begin
                        m_active   = 1'b1;
                        m_issue_at = n + 1;
                    end
                end else if (issuing) begin
                    m_issue_at   = -1;
                    m_wait_start = n;
                end else if (waiting) begin
                    if (mv) begin
                        m_cnt++;
                        m_operand = mul;
                        if (m_cnt == m_iters) begin
                            m_result = mul; m_active = 1'b0; m_done_at = n + 1;
                        end else begin
                            m_issue_at = n + 1;
                        end
                    end else if (n - m_wait_start == TMO) begin
                        m_err[0] = 1'b1; m_active = 1'b0; m_rst_left = 2;
                    end
                end
                if (mv && !waiting) m_err[1] = 1'b1;
            end
        end
    endtask

    task automatic start_run(input longint unsigned v, input longint unsigned it, output int s);
        drv_sq = v; drv_iters = it; drv_start = 1'b1; resp_no = 0;
        step();
        s = last_n;
        drv_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        int d0 = n_done;
        while (n_done == d0 && k < budget) begin
            step();
            k++;
        end
        if (n_done == d0) flag(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int s, t, i0, d0;
        longint unsigned x;
        mif.i_mont_val = 1'b0;
        mif.i_mont_mul = '0;
        repeat (3) step();
        drv_rst = 1'b0;
        step();
        chk("reset_mont_rst", 64'(mif.o_mont_rst), 64'd1);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        repeat (3) step();
        chk("mont_rst_released", 64'(mif.o_mont_rst), 64'd0);

        // 1: single squaring
        i0 = n_issue;
        start_run(64'd3, 64'd1, s);
        wait_done(200, "s1_done");
        chk("s1_latency", 64'(done_cyc - s), 64'(L + 3));
        chk("s1_result", 64'(result), 64'd9);
        chk("s1_iter_cnt", iter_cnt, 64'd1);
        chk("s1_issues", 64'(n_issue - i0), 64'd1);
        repeat (2) step();

        // 2: zero iterations
        i0 = n_issue;
        start_run(64'd5, 64'd0, s);
        wait_done(20, "s2_done");
        chk("s2_latency", 64'(done_cyc - s), 64'd1);
        chk("s2_result", 64'(result), 64'd5);
        chk("s2_issues", 64'(n_issue - i0), 64'd0);
        repeat (2) step();

        // four squarings: 3 -> 9 -> 81 -> 6561 -> 46592 (mod 1000003)
        start_run(64'd3, 64'd4, s);
        wait_done(200, "s4it_done");
        chk("s4it_result", 64'(result), 64'd46592);
        chk("s4it_latency", 64'(done_cyc - s), 64'd41);
        repeat (2) step();

        // 3: one hundred squarings
        i0 = n_issue;
        start_run(64'd3, 64'd100, s);
        wait_done(2000, "s3_done");
        x = 64'd3;
        for (int k = 0; k < 100; k++) x = (x * x) % NMOD;
        chk("s3_result", 64'(result), x);
        chk("s3_issues", 64'(n_issue - i0), 64'd100);
        chk("s3_iter_cnt", iter_cnt, 64'd100);
        chk("s3_latency", 64'(done_cyc - s), 64'(100 * (L + 2) + 1));
        repeat (2) step();

        // 6: start during WAIT ignored, spurious result in IDLE flagged
        i0 = n_issue;
        start_run(64'd3, 64'd3, s);
        repeat (4) step();
        drv_sq = 64'd7; drv_iters = 64'd1; drv_start = 1'b1;
        step();
        drv_start = 1'b0;
        wait_done(200, "s6_done");
        chk("s6_result", 64'(result), 64'd6561);
        chk("s6_iter_cnt", iter_cnt, 64'd3);
        chk("s6_issues", 64'(n_issue - i0), 64'd3);
        chk("s6_latency", 64'(done_cyc - s), 64'(3 * (L + 2) + 1));
        repeat (2) step();
        drv_spur = 1'b1;
        step();
        drv_spur = 1'b0;
        repeat (2) step();
        chk("s6_spur_err", 64'(err), 64'd2);
        chk("s6_spur_cnt", iter_cnt, 64'd3);

        // 4: datapath stops responding
        mont_on = 1'b0;
        d0 = n_done;
        start_run(64'd3, 64'd5, s);
        t = 0;
        for (int k = 0; k < TMO + 50 && t == 0; k++) begin
            step();
            if (err[0]) t = last_n;
        end
        if (t == 0) flag("s4_timeout_seen");
        chk("s4_tmo_cycle", 64'(t - s), 64'(TMO + 2));
        chk("s4_rst0", 64'(mif.o_mont_rst), 64'd1);
        chk("s4_busy", 64'(busy), 64'd0);
        step();
        chk("s4_rst1", 64'(mif.o_mont_rst), 64'd1);
        step();
        chk("s4_rst2", 64'(mif.o_mont_rst), 64'd0);
        chk("s4_no_done", 64'(n_done - d0), 64'd0);
        mont_on = 1'b1;
        repeat (2) step();

        // 5: abort together with the 7th result
        d0 = n_done;
        i0 = n_issue;
        abort_at_resp = 7;
        start_run(64'd3, 64'd20, s);
        repeat (2) step();
        chk("s5_err_cleared", 64'(err), 64'd0);
        for (int k = 0; k < 200 && resp_no < 7; k++) step();
        if (resp_no < 7) flag("s5_resp7");
        abort_at_resp = 0;
        repeat (3) step();
        chk("s5_iter_cnt", iter_cnt, 64'd6);
        chk("s5_busy", 64'(busy), 64'd0);
        chk("s5_issues", 64'(n_issue - i0), 64'd7);
        chk("s5_no_done", 64'(n_done - d0), 64'd0);
        drv_spur = 1'b1;
        step();
        drv_spur = 1'b0;
        repeat (2) step();
        chk("s5_spur_err", 64'(err), 64'd2);
        start_run(64'd3, 64'd1, s);
        wait_done(200, "s5_rerun_done");
        chk("s5_rerun_result", 64'(result), 64'd9);
        chk("s5_rerun_err", 64'(err), 64'd0);
        chk("s5_rerun_latency", 64'(done_cyc - s), 64'(L + 3));
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
